// File: rtl/softreg_resp_router_if.sv
// -----------------------------------------------------------------------------
// softreg_resp_router_if
// Bus bundle for the soft-register response router.
//   Snooped request side (driven by the request merge):
//     req_valid       request issued to the app this cycle
//     req_is_write    request is a write (writes never produce a response)
//     req_src         issuer of the request: 0 = aos internal, 1 = aos host
//   App response side:
//     resp_in_valid / resp_in_data       response coming back from the app
//   Routed responses (registered inside the router):
//     resp_int_valid / resp_int_data     response to aos internal
//     resp_host_valid / resp_host_data   response to aos host
// Only the request fields the router actually looks at are carried here;
// address and write data of the snooped request are irrelevant to routing.
// Modports: master = environment side, slave = router side.
// -----------------------------------------------------------------------------
interface softreg_resp_router_if;
  logic        req_valid;
  logic        req_is_write;
  logic        req_src;
  logic        resp_in_valid;
  logic [63:0] resp_in_data;
  logic        resp_int_valid;
  logic [63:0] resp_int_data;
  logic        resp_host_valid;
  logic [63:0] resp_host_data;

  modport master (
    output req_valid, req_is_write, req_src, resp_in_valid, resp_in_data,
    input  resp_int_valid, resp_int_data, resp_host_valid, resp_host_data
  );

  modport slave (
    input  req_valid, req_is_write, req_src, resp_in_valid, resp_in_data,
    output resp_int_valid, resp_int_data, resp_host_valid, resp_host_data
  );
endinterface

// File: rtl/softreg_resp_router.sv
// -----------------------------------------------------------------------------
// softreg_resp_router
// Return path of the two-source soft-register merge. Every read issued to the
// app records its source in an in-order tag FIFO; each app response pops the
// head tag and is steered to that source one cycle later. Apps answer reads in
// order, so the head tag always belongs to the response being returned.
//
// Optional feature (macro SOFTREG_RESP_TIMEOUT_EN):
//   a timer watches the oldest read; after TIMEOUT_CYC cycles without a
//   response the head is popped and TIMEOUT_DATA is returned to its owner.
//   The late app response for that read is later discarded (drop_pend) so the
//   in-order pairing between tags and responses is preserved.
//   Without the macro reads wait indefinitely and o_timeout_cnt is 0.
//
// Ports:
//   i_clk           user clock
//   i_rst_n         synchronous active-low reset
//   bus             softreg_resp_router_if.slave (request snoop, app
//                   response in, routed responses out)
//   o_outstanding   reads currently tracked in the tag FIFO (LOG_DEPTH+1 bits)
//   o_err_overflow  sticky: read issued while the FIFO was full (untracked)
//   o_err_underflow sticky: app response with nothing outstanding
//   o_timeout_cnt   saturating count of synthesized timeout responses
// -----------------------------------------------------------------------------
module softreg_resp_router #(
  parameter int LOG_DEPTH = 4
`ifdef SOFTREG_RESP_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC  = 1024,
  parameter logic [63:0] TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  softreg_resp_router_if.slave  bus,
  output logic [LOG_DEPTH:0]    o_outstanding,
  output logic                  o_err_overflow,
  output logic                  o_err_underflow,
  output logic [15:0]           o_timeout_cnt
);

  localparam int            DEPTH   = 1 << LOG_DEPTH;
  localparam int            PW      = LOG_DEPTH + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_tags [DEPTH];

  logic          r_int_valid;
  logic [63:0]   r_int_data;
  logic          r_host_valid;
  logic [63:0]   r_host_data;
  logic          r_err_overflow;
  logic          r_err_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_head_tag;
  logic          w_push_req;
  logic          w_push;
  logic          w_app_pop;
  logic          w_tmo_pop;
  logic          w_pop;
  logic          w_drop;
  logic          w_underflow;
  logic          w_overflow;
  logic [63:0]   w_tmo_data;
  logic [63:0]   w_resp_data;
  logic          w_to_int;
  logic          w_to_host;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                         (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign w_head_tag    = r_tags[r_rd_ptr[PW-2:0]];
  assign o_outstanding = r_wr_ptr - r_rd_ptr;

  assign w_push_req    = bus.req_valid && !bus.req_is_write;

`ifdef SOFTREG_RESP_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [PW-1:0] DROP_MAX = {PW{1'b1}};

  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_drop_pend;
  logic [15:0]   r_timeout_cnt;

  // Responses owed for reads already answered by a timeout are swallowed.
  assign w_drop     = bus.resp_in_valid && (r_drop_pend != {PW{1'b0}});
  // Any app response this cycle (routed or dropped) pre-empts the timeout.
  assign w_tmo_pop  = !w_empty && !bus.resp_in_valid && (r_timer >= TMO_LAST);
  assign w_tmo_data = TIMEOUT_DATA;

  // Timeout timer, pending-drop counter and saturating timeout counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timer       <= {TW{1'b0}};
      r_drop_pend   <= {PW{1'b0}};
      r_timeout_cnt <= 16'h0000;
    end else begin
      // Timer holds at its last value if a dropped response blocks the timeout.
      if (w_pop || w_empty) begin
        r_timer <= {TW{1'b0}};
      end else if (r_timer < TMO_LAST) begin
        r_timer <= r_timer + TMR_ONE;
      end else begin
        r_timer <= r_timer;
      end

      if (w_tmo_pop && (r_drop_pend != DROP_MAX)) begin
        r_drop_pend <= r_drop_pend + PTR_ONE;
      end else if (w_drop) begin
        r_drop_pend <= r_drop_pend - PTR_ONE;
      end else begin
        r_drop_pend <= r_drop_pend;
      end

      if (w_tmo_pop && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'h0001;
      end else begin
        r_timeout_cnt <= r_timeout_cnt;
      end
    end
  end

  assign o_timeout_cnt = r_timeout_cnt;
`else
  assign w_drop        = 1'b0;
  assign w_tmo_pop     = 1'b0;
  assign w_tmo_data    = 64'h0000_0000_0000_0000;
  assign o_timeout_cnt = 16'h0000;
`endif

  // Pop decisions look only at FIFO state before this cycle's push.
  assign w_app_pop   = bus.resp_in_valid && !w_drop && !w_empty;
  assign w_underflow = bus.resp_in_valid && !w_drop && w_empty;
  assign w_pop       = w_app_pop || w_tmo_pop;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_overflow  = w_push_req && w_full && !w_pop;

  // Select the routed payload and its destination for this cycle.
  always_comb begin
    w_resp_data = 64'h0000_0000_0000_0000;
    w_to_int    = 1'b0;
    w_to_host   = 1'b0;
    if (w_app_pop) begin
      w_resp_data = bus.resp_in_data;
    end else if (w_tmo_pop) begin
      w_resp_data = w_tmo_data;
    end else begin
      w_resp_data = 64'h0000_0000_0000_0000;
    end
    if (w_pop) begin
      w_to_int  = !w_head_tag;
      w_to_host = w_head_tag;
    end else begin
      w_to_int  = 1'b0;
      w_to_host = 1'b0;
    end
  end

  // Tag storage; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr[PW-2:0]] <= bus.req_src;
    end
  end

  // FIFO pointers, sticky errors and registered (zeroed when idle) response outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr        <= {PW{1'b0}};
      r_rd_ptr        <= {PW{1'b0}};
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_int_valid     <= 1'b0;
      r_int_data      <= 64'h0000_0000_0000_0000;
      r_host_valid    <= 1'b0;
      r_host_data     <= 64'h0000_0000_0000_0000;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_err_overflow  <= r_err_overflow  | w_overflow;
      r_err_underflow <= r_err_underflow | w_underflow;
      r_int_valid     <= w_to_int;
      r_int_data      <= w_to_int  ? w_resp_data : 64'h0000_0000_0000_0000;
      r_host_valid    <= w_to_host;
      r_host_data     <= w_to_host ? w_resp_data : 64'h0000_0000_0000_0000;
    end
  end

  assign bus.resp_int_valid  = r_int_valid;
  assign bus.resp_int_data   = r_int_data;
  assign bus.resp_host_valid = r_host_valid;
  assign bus.resp_host_data  = r_host_data;
  assign o_err_overflow      = r_err_overflow;
  assign o_err_underflow     = r_err_underflow;

endmodule

// File: tb/tb_softreg_resp_router.sv
// -----------------------------------------------------------------------------
// tb_softreg_resp_router
// Scoreboard bench for softreg_resp_router. Directed stimulus pushes the
// expected {destination, data, arrival cycle} for every response that must be
// routed; a negedge monitor pops and compares whenever an output is valid and
// checks idle outputs carry zero data. Status outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_softreg_resp_router;

  typedef struct {
    bit          src;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  localparam logic [63:0] TMO_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

  logic        clk;
  logic        rst_n;
  logic [4:0]  outstanding;
  logic        err_overflow;
  logic        err_underflow;
  logic [15:0] timeout_cnt;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  bit   mon_en;
  exp_t exp_q[$];

  softreg_resp_router_if bus ();

  softreg_resp_router #(
    .LOG_DEPTH(4)
`ifdef SOFTREG_RESP_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8),
    .TIMEOUT_DATA(64'hDEAD_DEAD_DEAD_DEAD)
`endif
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_outstanding  (outstanding),
    .o_err_overflow (err_overflow),
    .o_err_underflow(err_underflow),
    .o_timeout_cnt  (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expect a routed response 'off' cycles after the current cycle count.
  task automatic expect_resp(input bit src, input logic [63:0] data, input int off);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.cyc  = cyc + off;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic drive(input bit rd, input bit wr, input bit src, input bit rsp, input logic [63:0] d);
    bus.req_valid     = rd | wr;
    bus.req_is_write  = wr;
    bus.req_src       = src;
    bus.resp_in_valid = rsp;
    bus.resp_in_data  = d;
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.req_is_write  = 1'b0;
    bus.req_src       = 1'b0;
    bus.resp_in_valid = 1'b0;
    bus.resp_in_data  = 64'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  // Monitor: every routed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (bus.resp_int_valid === 1'b1 || bus.resp_host_valid === 1'b1) begin
        if (bus.resp_int_valid === 1'b1 && bus.resp_host_valid === 1'b1) begin
          n_bad++;
          $display("FAIL both_valid: int and host valid together at cycle %0d", cyc);
        end else if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_resp: int_v=%0b host_v=%0b at cycle %0d, none expected",
                   bus.resp_int_valid, bus.resp_host_valid, cyc);
        end else begin
          exp_t        e;
          bit          a_src;
          logic [63:0] a_data;
          logic [63:0] o_data;
          e      = exp_q.pop_front();
          a_src  = bus.resp_host_valid;
          a_data = a_src ? bus.resp_host_data : bus.resp_int_data;
          o_data = a_src ? bus.resp_int_data  : bus.resp_host_data;
          if (a_src !== e.src || a_data !== e.data || cyc != e.cyc || o_data !== 64'h0) begin
            n_bad++;
            $display("FAIL route: got src=%0b data=%0h cyc=%0d other=%0h expected src=%0b data=%0h cyc=%0d other=0",
                     a_src, a_data, cyc, o_data, e.src, e.data, e.cyc);
          end
        end
      end else begin
        if (bus.resp_int_valid !== 1'b0 || bus.resp_host_valid !== 1'b0 ||
            bus.resp_int_data !== 64'h0 || bus.resp_host_data !== 64'h0) begin
          n_bad++;
          $display("FAIL idle_outputs: int=%0b/%0h host=%0b/%0h expected 0/0 0/0",
                   bus.resp_int_valid, bus.resp_int_data, bus.resp_host_valid, bus.resp_host_data);
        end
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    mon_en = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_is_write  = 1'b0;
    bus.req_src       = 1'b0;
    bus.resp_in_valid = 1'b0;
    bus.resp_in_data  = 64'h0;

    // Reset state
    do_reset(2);
    mon_en = 1'b1;
    chk("rst_int_valid", 64'(bus.resp_int_valid), 64'd0);
    chk("rst_host_valid", 64'(bus.resp_host_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_ovf", 64'(err_overflow), 64'd0);
    chk("rst_err_udf", 64'(err_underflow), 64'd0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);

    // Reads int, host, int then three in-order responses
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("three_outstanding", 64'(outstanding), 64'd3);
    expect_resp(1'b0, 64'h0000_0000_0000_00D0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00D0);
    expect_resp(1'b1, 64'h1111_2222_3333_00D1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h1111_2222_3333_00D1);
    expect_resp(1'b0, 64'hFFFF_0000_FFFF_00D2, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_00D2);
    idle(1);
    chk("drained_outstanding", 64'(outstanding), 64'd0);

    // Host write is untracked; the stray response is an underflow
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("write_untracked", 64'(outstanding), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h55);
    idle(1);
    chk("write_underflow", 64'(err_underflow), 64'd1);

    // Full FIFO, 17th read coincides with a pop: accepted, no overflow
    do_reset(1);
    chk("reset_clears_udf", 64'(err_underflow), 64'd0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, i[0], 1'b0, 64'h0);
    chk("full_outstanding", 64'(outstanding), 64'd16);
    expect_resp(1'b0, 64'h0000_0000_0000_1000, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_1000);
    chk("push_pop_full_outstanding", 64'(outstanding), 64'd16);
    chk("push_pop_full_no_ovf", 64'(err_overflow), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      bit s;
      s = (k == 16) ? 1'b1 : k[0];
      expect_resp(s, 64'h0000_0000_0000_1000 + 64'(k), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_1000 + 64'(k));
    end
    idle(1);
    chk("full_drain_outstanding", 64'(outstanding), 64'd0);

    // Full FIFO, 17th read with no pop: overflow, read untracked
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, i[1], 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("overflow_flag", 64'(err_overflow), 64'd1);
    chk("overflow_outstanding", 64'(outstanding), 64'd16);
    for (int k = 0; k < 16; k++) begin
      expect_resp(k[1], 64'hABCD_0000_0000_0000 + 64'(k), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hABCD_0000_0000_0000 + 64'(k));
    end
    idle(1);
    chk("overflow_drain_no_udf", 64'(err_underflow), 64'd0);

    // Reset with reads outstanding discards all tags
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    do_reset(1);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_err_ovf", 64'(err_overflow), 64'd0);
    chk("midrst_int_data", bus.resp_int_data, 64'd0);
    chk("midrst_host_data", bus.resp_host_data, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
    idle(1);
    chk("late_resp_underflow", 64'(err_underflow), 64'd1);

    // Response with nothing outstanding plus a same-cycle read: dropped, read tracked
    do_reset(1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h99);
    chk("empty_pushpop_udf", 64'(err_underflow), 64'd1);
    chk("empty_pushpop_outstanding", 64'(outstanding), 64'd1);
    expect_resp(1'b1, 64'h0000_0000_0000_0123, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0123);
    idle(1);

`ifdef SOFTREG_RESP_TIMEOUT_EN
    // Host read times out after 8 cycles; the late response is discarded
    do_reset(1);
    expect_resp(1'b1, TMO_DATA, 9);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    idle(9);
    chk("timeout_cnt", 64'(timeout_cnt), 64'd1);
    chk("timeout_outstanding", 64'(outstanding), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0BAD);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    expect_resp(1'b0, 64'h0000_0000_0000_600D, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_600D);
    idle(1);
    chk("late_drop_no_udf", 64'(err_underflow), 64'd0);
`else
    chk("timeout_cnt_tied", 64'(timeout_cnt), 64'd0);
`endif

    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
